// File: rtl/store_buffer_pkg.sv
// Shared types and load/store width encodings for the MEM-stage store path.
// The LS_*_OP codes are the single source used by both load writeback and the store buffer.
package store_buffer_pkg;

  localparam logic [2:0] LS_B_OP = 3'b000;
  localparam logic [2:0] LS_H_OP = 3'b001;
  localparam logic [2:0] LS_W_OP = 3'b010;

  typedef struct packed {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } sb_entry_t;

  localparam int SB_ENTRY_W = $bits(sb_entry_t);

endpackage

// File: rtl/store_fifo.sv
// Synchronous DEPTH-entry FIFO for formatted store beats; head is read straight from storage.
// Handshake: push_i is honoured only when not full, pop_i only when not empty.
module store_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = SB_ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/store_buffer.sv
// RV32 store formatter and write queue: lane-replicates store data, builds byte strobes,
// faults misaligned/illegal stores and drains legal ones over a valid/ready write channel.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_data,
  input  logic [2:0]      i_funct3,
  output logic            o_fault,
  output logic [XLEN-1:0] o_fault_addr,
  output logic            o_empty,
  output logic            mem_wvalid,
  input  logic            mem_wready,
  output logic [XLEN-1:0] mem_waddr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb
);

  // Both channels: a beat transfers on a rising edge where valid & ready are both high.
  sb_entry_t       entry_d;
  sb_entry_t       head;
  logic            legal_d;
  logic [1:0]      lane;
  logic            accept;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fault_q;
  logic [XLEN-1:0] fault_addr_q;

  assign lane = i_addr[1:0];

  always_comb begin
    entry_d       = '0;
    legal_d       = 1'b0;
    entry_d.waddr = {i_addr[31:2], 2'b00};
    case (i_funct3)
      LS_B_OP: begin
        entry_d.wdata = {4{i_data[7:0]}};
        entry_d.wstrb = 4'b0001 << lane;
        legal_d       = 1'b1;
      end
      LS_H_OP: begin
        entry_d.wdata = {2{i_data[15:0]}};
        entry_d.wstrb = i_addr[1] ? 4'b1100 : 4'b0011;
        legal_d       = ~i_addr[0];
      end
      LS_W_OP: begin
        entry_d.wdata = i_data;
        entry_d.wstrb = 4'b1111;
        legal_d       = (lane == 2'b00);
      end
      default: legal_d = 1'b0;
    endcase
  end

  assign i_ready = ~fifo_full;
  assign accept  = i_valid & i_ready;

  store_fifo #(
    .DEPTH (DEPTH),
    .W     (SB_ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept & legal_d),
    .push_data_i (entry_d),
    .pop_i       (mem_wready),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign mem_wvalid = ~fifo_empty;
  assign o_empty    = fifo_empty;
  assign mem_waddr  = head.waddr;
  assign mem_wdata  = head.wdata;
  assign mem_wstrb  = head.wstrb;

  // Illegal requests are consumed silently except for this one-cycle report.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q <= accept & ~legal_d;
      if (accept & ~legal_d) fault_addr_q <= i_addr;
    end
  end

  assign o_fault      = fault_q;
  assign o_fault_addr = fault_addr_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a scoreboard of expected write beats.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic [2:0]  i_funct3;
  logic        o_fault;
  logic [31:0] o_fault_addr;
  logic        o_empty;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int n_checks = 0;
  int n_errors = 0;
  logic [67:0] exp_q[$];

  store_buffer #(.DEPTH(2), .XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_ready      (i_ready),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .i_funct3     (i_funct3),
    .o_fault      (o_fault),
    .o_fault_addr (o_fault_addr),
    .o_empty      (o_empty),
    .mem_wvalid   (mem_wvalid),
    .mem_wready   (mem_wready),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [31:0] a, input logic [2:0] f);
    case (f)
      3'b000:  return 1'b1;
      3'b001:  return (a[0] == 1'b0);
      3'b010:  return (a[1:0] == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [67:0] fmt(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    logic [31:0] wd;
    logic [3:0]  st;
    wd = d;
    st = 4'b1111;
    if (f == 3'b000) begin
      wd = {d[7:0], d[7:0], d[7:0], d[7:0]};
      case (a[1:0])
        2'd0: st = 4'b0001;
        2'd1: st = 4'b0010;
        2'd2: st = 4'b0100;
        default: st = 4'b1000;
      endcase
    end else if (f == 3'b001) begin
      wd = {d[15:0], d[15:0]};
      st = a[1] ? 4'b1100 : 4'b0011;
    end
    return {a[31:2], 2'b00, wd, st};
  endfunction

  // Beat monitor: every completed write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && mem_wvalid && mem_wready) begin
      if (exp_q.size() == 0) check("unexpected_beat", {mem_waddr, mem_wdata, mem_wstrb}, 68'h0);
      else check("beat", {mem_waddr, mem_wdata, mem_wstrb}, exp_q.pop_front());
    end
  end

  // Called and returns just after a rising edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    bit done;
    int t;
    done = 0;
    t = 0;
    i_valid = 1'b1; i_addr = a; i_data = d; i_funct3 = f;
    while (!done && t < 50) begin
      @(negedge clk);
      if (i_ready) begin
        done = 1;
        if (is_legal(a, f)) exp_q.push_back(fmt(a, d, f));
      end
      @(posedge clk); #1;
      t++;
    end
    if (!done) check("send_timeout", 68'(0), 68'(1));
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && o_empty) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("drained", 68'({exp_q.size() == 0, o_empty}), 68'(2'b11));
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_addr = '0; i_data = '0; i_funct3 = '0; mem_wready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_i_ready",     68'(i_ready),      68'(1));
    check("rst_wvalid",      68'(mem_wvalid),   68'(0));
    check("rst_fault",       68'(o_fault),      68'(0));
    check("rst_empty",       68'(o_empty),      68'(1));
    check("rst_fault_addr",  68'(o_fault_addr), 68'(0));
    check("rst_payload",     {mem_waddr, mem_wdata, mem_wstrb}, 68'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // SB to lane 3, one beat, valid the cycle after accept
    mem_wready = 1'b1;
    send(32'h0000_1003, 32'hAABB_CC5A, 3'b000);
    check("sb_latency", 68'(mem_wvalid), 68'(1));
    check("sb_no_fault", 68'(o_fault), 68'(0));
    check("sb_fmt_model", fmt(32'h1003, 32'hAABBCC5A, 3'b000), {32'h1000, 32'h5A5A5A5A, 4'b1000});
    drain();

    // SH upper half then SW, in order
    send(32'h0000_2002, 32'h1234_BEEF, 3'b001);
    send(32'h0000_2004, 32'hCAFE_F00D, 3'b010);
    drain();

    // misaligned SW and an unsupported funct3 both fault without a beat
    send(32'h0000_3001, 32'h1111_2222, 3'b010);
    check("sw_mis_fault",      68'(o_fault),      68'(1));
    check("sw_mis_fault_addr", 68'(o_fault_addr), 68'(32'h3001));
    check("sw_mis_no_beat",    68'(mem_wvalid),   68'(0));
    @(posedge clk); #1;
    check("sw_mis_pulse_end",  68'(o_fault),      68'(0));
    send(32'h0000_3100, 32'h3333_4444, 3'b100);
    check("f3_100_fault",      68'(o_fault),      68'(1));
    check("f3_100_fault_addr", 68'(o_fault_addr), 68'(32'h3100));
    check("f3_100_no_beat",    68'(mem_wvalid),   68'(0));
    @(posedge clk); #1;
    check("f3_100_pulse_end",  68'(o_fault),      68'(0));
    send(32'h0000_3202, 32'h5555_6666, 3'b001);
    check("sh_legal_no_fault", 68'(o_fault),      68'(0));
    drain();

    // backpressure: fill with two SW, hold payload, then full+pop same cycle
    mem_wready = 1'b0;
    send(32'h0000_4000, $urandom_range(0, 32'hFFFF), 3'b010);
    send(32'h0000_4004, 32'hA5A5_0001, 3'b010);
    check("full_i_ready", 68'(i_ready), 68'(0));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_payload", {mem_waddr, mem_wdata, mem_wstrb}, exp_q[0]);
      check("hold_valid", 68'(mem_wvalid), 68'(1));
    end
    @(posedge clk); #1;
    i_valid = 1'b1; i_addr = 32'h0000_4008; i_data = 32'hA5A5_0002; i_funct3 = 3'b010;
    mem_wready = 1'b1;
    @(negedge clk);
    check("full_pop_no_bypass", 68'(i_ready), 68'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_pop", 68'(i_ready), 68'(1));
    if (i_ready) exp_q.push_back(fmt(i_addr, i_data, i_funct3));
    @(posedge clk); #1;
    i_valid = 1'b0;
    drain();

    // reset with two entries queued discards them
    mem_wready = 1'b0;
    send(32'h0000_5000, 32'hDEAD_0000, 3'b010);
    send(32'h0000_5001, 32'hDEAD_00EE, 3'b000);
    check("pre_rst_wvalid", 68'(mem_wvalid), 68'(1));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_mid_wvalid",  68'(mem_wvalid), 68'(0));
    check("rst_mid_empty",   68'(o_empty),    68'(1));
    check("rst_mid_i_ready", 68'(i_ready),    68'(1));
    rst = 1'b0;
    mem_wready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_empty", 68'(o_empty), 68'(1));
    check("final_queue", 68'(exp_q.size()), 68'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
